// File: rtl/gpu_pkg.sv
// Shared types and default widths for the GPU memory path.
// Arbiter FSM states live here so other blocks can decode them.
package gpu_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESPOND
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request after last winner.
// Purely combinational; shared by the memory arbiter and warp scheduler.
module rr_pick #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          any,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   // scan N slots starting just past the previous winner
   always_comb begin
      int j;
      j     = 0;
      any   = 1'b0;
      grant = '0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(last) + k) % N;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the shared data-memory port.
// One transaction in flight; fields latched at grant.
module mem_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int ADDR_W  = gpu_pkg::ADDR_W,
   parameter  int DATA_W  = gpu_pkg::DATA_W,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      mem_valid,
   input  logic                      mem_ready,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic                      mem_rsp_valid,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      busy,
   output logic [ID_W-1:0]           grant_id
);

   import gpu_pkg::*;

   arb_state_t         state;
   logic [ID_W-1:0]    last_grant;
   logic [NUM_REQ-1:0] grant_oh;
   logic               pick_any;
   logic [NUM_REQ-1:0] pick_oh;
   logic [ID_W-1:0]    pick_idx;

   rr_pick #(
      .N(NUM_REQ)
   ) u_pick (
      .req  (req_valid),
      .last (last_grant),
      .any  (pick_any),
      .grant(pick_oh),
      .idx  (pick_idx)
   );

   // arbiter FSM with request latch and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= ID_W'(NUM_REQ - 1);
         grant_oh   <= '0;
         grant_id   <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_any) begin
                  grant_id  <= pick_idx;
                  grant_oh  <= pick_oh;
                  mem_we    <= req_we[pick_idx];
                  mem_addr  <=
                     req_addr[pick_idx*ADDR_W +: ADDR_W];
                  mem_wdata <=
                     req_wdata[pick_idx*DATA_W +: DATA_W];
                  mem_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (mem_rsp_valid) begin
                  rsp_rdata <= mem_rdata;
                  rsp_valid <= grant_oh;
                  state     <= RESPOND;
               end
            end
            RESPOND: begin
               rsp_valid  <= '0;
               last_grant <= grant_id;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Memory side is driven by hand step by step.
module tb_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 8;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]  rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          mem_valid;
   logic          mem_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_rsp_valid;
   logic [DW-1:0] mem_rdata;
   logic          busy;
   logic [1:0]    grant_id;

   int total;
   int fails;

   mem_arbiter #(
      .NUM_REQ(N),
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rdata    (mem_rdata),
      .busy         (busy),
      .grant_id     (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // one fast transaction from IDLE: ready held high
   task automatic xact(input int id, input logic [7:0] rd);
      logic [3:0] oh;
      oh = 4'b0001 << id;
      tick();
      chk("x_grant", 32'(grant_id), 32'(id));
      chk("x_mvalid", 32'(mem_valid), 1);
      tick();
      mem_rsp_valid = 1'b1;
      mem_rdata     = rd;
      tick();
      mem_rsp_valid = 1'b0;
      chk("x_rsp", 32'(rsp_valid), 32'(oh));
      chk("x_rdata", 32'(rsp_rdata), 32'(rd));
      tick();
   endtask

   initial begin
      total         = 0;
      fails         = 0;
      rst_n         = 1'b0;
      req_valid     = '0;
      req_we        = '0;
      req_addr      = '0;
      req_wdata     = '0;
      mem_ready     = 1'b1;
      mem_rsp_valid = 1'b0;
      mem_rdata     = '0;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mvalid", 32'(mem_valid), 0);
      chk("rst_rsp", 32'(rsp_valid), 0);
      chk("rst_gid", 32'(grant_id), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      rst_n = 1'b1;
      tick();

      // fairness: all valid, held across responses
      req_valid = 4'b1111;
      xact(0, 8'h10);
      xact(1, 8'h11);
      xact(2, 8'h12);
      xact(3, 8'h13);
      xact(0, 8'h14);
      xact(1, 8'h15);
      req_valid = '0;
      tick();

      // single read from req 0
      req_valid     = 4'b0001;
      req_addr[7:0] = 8'h12;
      tick();
      chk("sr_mvalid", 32'(mem_valid), 1);
      chk("sr_addr", 32'(mem_addr), 32'h12);
      chk("sr_we", 32'(mem_we), 0);
      tick();
      chk("sr_wait_mv", 32'(mem_valid), 0);
      mem_rsp_valid = 1'b1;
      mem_rdata     = 8'hAB;
      tick();
      mem_rsp_valid = 1'b0;
      req_valid     = '0;
      chk("sr_rsp", 32'(rsp_valid), 32'h1);
      chk("sr_rdata", 32'(rsp_rdata), 32'hAB);
      tick();
      chk("sr_idle_rsp", 32'(rsp_valid), 0);
      chk("sr_idle_busy", 32'(busy), 0);

      // backpressure: req 2 write, ready low 3 cycles
      mem_ready         = 1'b0;
      req_valid         = 4'b0100;
      req_we            = 4'b0100;
      req_addr[23:16]   = 8'h40;
      req_wdata[23:16]  = 8'h5A;
      tick();
      req_addr[23:16]   = 8'h41;
      req_wdata[23:16]  = 8'h00;
      for (int c = 0; c < 4; c++) begin
         chk("bp_mv", 32'(mem_valid), 1);
         chk("bp_addr", 32'(mem_addr), 32'h40);
         chk("bp_wd", 32'(mem_wdata), 32'h5A);
         chk("bp_we", 32'(mem_we), 1);
         chk("bp_rsp", 32'(rsp_valid), 0);
         if (c == 3) mem_ready = 1'b1;
         tick();
      end
      chk("bp_wait_mv", 32'(mem_valid), 0);
      mem_rsp_valid = 1'b1;
      mem_rdata     = 8'hEE;
      tick();
      mem_rsp_valid = 1'b0;
      req_valid     = '0;
      req_we        = '0;
      chk("bp_rsp1", 32'(rsp_valid), 32'h4);
      tick();
      chk("bp_rsp2", 32'(rsp_valid), 0);
      tick();
      chk("bp_rsp3", 32'(rsp_valid), 0);

      // spurious memory signals
      mem_rsp_valid = 1'b1;
      mem_ready     = 1'b1;
      tick();
      chk("sp_idle_busy", 32'(busy), 0);
      chk("sp_idle_rsp", 32'(rsp_valid), 0);
      mem_ready = 1'b0;
      req_valid = 4'b0010;
      tick();
      tick();
      chk("sp_iss_mv", 32'(mem_valid), 1);
      chk("sp_iss_rsp", 32'(rsp_valid), 0);
      chk("sp_iss_gid", 32'(grant_id), 1);
      mem_rsp_valid = 1'b0;
      mem_ready     = 1'b1;
      tick();
      tick();
      chk("sp_wait_mv", 32'(mem_valid), 0);
      chk("sp_wait_busy", 32'(busy), 1);
      chk("sp_wait_rsp", 32'(rsp_valid), 0);
      mem_rsp_valid = 1'b1;
      mem_rdata     = 8'h77;
      tick();
      mem_rsp_valid = 1'b0;
      req_valid     = '0;
      chk("sp_rsp", 32'(rsp_valid), 32'h2);
      chk("sp_rdata", 32'(rsp_rdata), 32'h77);
      tick();

      // reset while in WAIT
      req_valid     = 4'b0001;
      req_addr[7:0] = 8'h33;
      tick();
      tick();
      chk("rw_busy_pre", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rw_busy", 32'(busy), 0);
      chk("rw_mv", 32'(mem_valid), 0);
      chk("rw_addr", 32'(mem_addr), 0);
      chk("rw_gid", 32'(grant_id), 0);
      chk("rw_rdata", 32'(rsp_rdata), 0);
      tick();
      rst_n     = 1'b1;
      req_valid = 4'b1010;
      tick();
      chk("rw_first", 32'(grant_id), 1);
      tick();
      mem_rsp_valid = 1'b1;
      tick();
      mem_rsp_valid = 1'b0;
      chk("rw_rsp", 32'(rsp_valid), 32'h2);
      req_valid = '0;
      tick();

      // late drop: req 3 appears then leaves during req 0
      req_valid = 4'b0001;
      tick();
      req_valid = 4'b1001;
      tick();
      req_valid = 4'b0001;
      mem_rsp_valid = 1'b1;
      tick();
      mem_rsp_valid = 1'b0;
      req_valid     = '0;
      chk("ld_rsp", 32'(rsp_valid), 32'h1);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("ld_gid", 32'(grant_id), 0);
         chk("ld_busy", 32'(busy), 0);
      end

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing the single data-memory port between `NUM_REQ` load/store requesters (one per core/LSU) inside `gpu_top`. Exactly one transaction is in flight at a time. Each transaction is latched at grant, issued to memory with a valid/ready handshake, and waits for the memory response. The read data or write acknowledge is then routed back to the granted requester as a one-cycle response pulse.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 8: memory data width.
- `ID_W`, `$clog2(NUM_REQ)`: grant index width (derived, not overridden).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request pending.
- `req_we`  in  NUM_REQ  per-requester write enable (1 = write).
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data, packed the same way.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `rsp_rdata`  out  DATA_W  read data, shared by all requesters; valid when any `rsp_valid` bit is high.
- `mem_valid`  out  1  request to memory.
- `mem_ready`  in  1  memory accepts the request.
- `mem_we`, `mem_addr`, `mem_wdata`  out  1/ADDR_W/DATA_W  latched request fields.
- `mem_rsp_valid`  in  1  memory completion (read data or write ack).
- `mem_rdata`  in  DATA_W  memory read data.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  ID_W  index of the current or last grantee.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- **IDLE**
  - If any `req_valid` bit is set, pick the grantee by round robin, searching from `last_grant+1` modulo NUM_REQ.
  - Latch the grantee's `we`, `addr` and `wdata`, and set `grant_id`.
  - Go to ISSUE. With no `req_valid` bits set, stay in IDLE.
- **ISSUE**
  - `mem_valid`=1, driven with the latched fields.
  - On `mem_ready`=1, go to WAIT. Otherwise hold; the fields stay stable while `mem_valid` is high.
- **WAIT**
  - `mem_valid`=0.
  - On `mem_rsp_valid`, capture `mem_rdata` into `rsp_rdata` and go to RESPOND.
  - Writes also wait for `mem_rsp_valid`; `rsp_rdata` still captures `mem_rdata` for writes, and requesters ignore it.
- **RESPOND**
  - `rsp_valid[grant_id]`=1 for exactly this cycle.
  - `last_grant` ← `grant_id`, then go to IDLE.
- Requester contract:
  - Hold `req_valid` and the request fields until the cycle in which `rsp_valid[i]` is high.
  - Clear `req_valid` on that same clock edge if no new request follows.
  - Changes to a requester's fields after grant are ignored, because the fields were latched.
- Boundary rules:
  - `mem_rsp_valid` in IDLE or ISSUE is ignored.
  - `mem_ready` outside ISSUE is ignored.
  - A requester that drops `req_valid` while another is granted simply loses its turn; no state is kept for it.
  - With a single active requester, it is granted back-to-back with no penalty beyond the FSM cycles.
- Reset (asynchronous, any state):
  - FSM → IDLE; `last_grant` ← NUM_REQ-1, so requester 0 has first priority.
  - All outputs reset to 0: `rsp_valid`, `rsp_rdata`, `mem_valid`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `grant_id`.
  - An in-flight memory transaction is abandoned. Memory must also be reset.

## Timing
- All outputs are registered or decoded from FSM state alone; no combinational path from `req_*` or `mem_*` inputs to outputs.
- Minimum latency: `req_valid` sampled in cycle 0 → `mem_valid` in cycle 1. With `mem_ready`=1 in cycle 1 and `mem_rsp_valid`=1 in cycle 2, `rsp_valid` is high in cycle 3.
- Throughput: one transaction per 4 cycles at best. Each ISSUE stall cycle and each WAIT cycle beyond the first adds one cycle.
- Next grant decision is made in the IDLE cycle following RESPOND.

## Structure
- `gpu_pkg` holds the `arb_state_t` enum (IDLE/ISSUE/WAIT/RESPOND) and shared default widths (`ADDR_W`, `DATA_W`).
- Sub-module `rr_pick`: combinational rotating-priority picker. Inputs are the request vector and `last_grant`. Outputs are `any` and a one-hot grant plus its index. It will be reused for warp scheduling.
- Top FSM, request latch and response register live in `mem_arbiter`.

## Test plan
- **Single read:** only req 0 valid, addr 0x12, memory returns 0xAB one cycle after `mem_ready`.
  - Expect `mem_valid` in cycle 1 and `mem_addr`=0x12, `mem_we`=0.
  - Expect `rsp_valid`=4'b0001 in cycle 3 with `rsp_rdata`=0xAB.
- **Round-robin fairness:** all 4 requesters held valid and re-asserted after each response.
  - Expect grant order 0,1,2,3,0,1.
  - Expect no `rsp_valid` on any bit other than the grantee.
- **Backpressure:** `mem_ready` low for 3 cycles in ISSUE, req 2 write (addr 0x40, wdata 0x5A).
  - Expect `mem_valid`/`mem_addr`/`mem_wdata`/`mem_we` stable for all 4 ISSUE cycles.
  - Expect `rsp_valid`=4'b0100 exactly once.
- **Spurious memory signals:** pulse `mem_rsp_valid` in IDLE and ISSUE, and `mem_ready` in WAIT.
  - Expect no state change and no `rsp_valid`.
- **Reset mid-operation:** assert `rst_n`=0 asynchronously while in WAIT.
  - Expect all outputs 0 immediately and `busy`=0.
  - After release, with reqs 1 and 3 valid, expect req 1 granted first.
- **Late drop:** req 3 deasserts while req 0 is being served.
  - Expect req 3 never granted and `grant_id` never equal to 3.
